// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the serial detector family.
package seq_pkg;

  localparam int SEQ_W  = 8;
  localparam int SEQ_CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_gen_if.sv
// Load handshake and serial output bundle of the pattern generator.
interface seq_gen_if
  import seq_pkg::*;
#(
  parameter int W  = SEQ_W,
  parameter int CW = SEQ_CW
) ();

  localparam int LW = $clog2(W + 1);

  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_pattern;
  logic [LW-1:0] load_len;
  logic [CW-1:0] load_reps;
  logic          pause;
  logic          data;
  logic          data_valid;
  logic          busy;
  logic          done;

  modport master (
    output load_valid, load_pattern, load_len, load_reps, pause,
    input  load_ready, data, data_valid, busy, done
  );

  modport slave (
    input  load_valid, load_pattern, load_len, load_reps, pause,
    output load_ready, data, data_valid, busy, done
  );

endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: loads a parallel pattern and sends it MSB-first,
// optionally repeated with idle gaps between repetitions and stalled by pause.
module seq_gen
  import seq_pkg::*;
#(
  parameter int W       = SEQ_W,
  parameter int CW      = SEQ_CW,
  parameter int GAP_CYC = 0
) (
  input logic     clk,
  input logic     rst_n,
  seq_gen_if.slave bus
);

  localparam int LW = $clog2(W + 1);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [LW-1:0] LEN_MAX  = LW'(W);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  seq_state_e    state_q;
  logic [W-1:0]  pat_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;
  logic [CW-1:0] reps_q;
  logic [GW-1:0] gap_q;
  logic          data_q;
  logic          data_valid_q;
  logic          busy_q;
  logic          done_q;

  logic          accept_s;
  logic [LW-1:0] in_len_s;
  logic [W-1:0]  sel_pat_s;
  logic [LW-1:0] sel_len_s;
  logic [LW-1:0] sel_idx_s;
  logic [CW-1:0] sel_reps_s;
  logic [LW-1:0] pos_s;
  logic [W-1:0]  shifted_s;
  logic          bit_s;
  logic          last_s;
  seq_state_e    adv_state_d;
  logic [LW-1:0] adv_idx_d;
  logic [CW-1:0] adv_reps_d;

  assign accept_s = (state_q == ST_IDLE) && bus.load_valid;

  // The handshake edge is also an emission edge, so the bit select reads the
  // load port directly while idle and the latched copy otherwise.
  always_comb begin
    in_len_s = bus.load_len;
    if ((bus.load_len == '0) || (bus.load_len > LEN_MAX)) begin
      in_len_s = LEN_MAX;
    end else begin
      in_len_s = bus.load_len;
    end
    if (state_q == ST_IDLE) begin
      sel_pat_s  = bus.load_pattern;
      sel_len_s  = in_len_s;
      sel_idx_s  = '0;
      sel_reps_s = bus.load_reps;
    end else begin
      sel_pat_s  = pat_q;
      sel_len_s  = len_q;
      sel_idx_s  = idx_q;
      sel_reps_s = reps_q;
    end
    pos_s     = sel_len_s - sel_idx_s - LW'(1);
    shifted_s = sel_pat_s >> pos_s;
    bit_s     = shifted_s[0];
    last_s    = (sel_idx_s == (sel_len_s - LW'(1)));
  end

  // Bit-index / repetition bookkeeping applied on every emitted beat.
  always_comb begin
    adv_state_d = ST_SHIFT;
    adv_idx_d   = sel_idx_s + LW'(1);
    adv_reps_d  = sel_reps_s;
    if (last_s) begin
      if (sel_reps_s == '0) begin
        adv_state_d = ST_FIN;
        adv_idx_d   = sel_idx_s;
      end else begin
        adv_idx_d  = '0;
        adv_reps_d = sel_reps_s - CW'(1);
        if (GAP_CYC > 0) begin
          adv_state_d = ST_GAP;
        end else begin
          adv_state_d = ST_SHIFT;
        end
      end
    end else begin
      adv_state_d = ST_SHIFT;
    end
  end

  // Generator FSM with registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pat_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      reps_q       <= '0;
      gap_q        <= '0;
      data_q       <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q       <= 1'b0;
          data_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          if (accept_s) begin
            pat_q  <= bus.load_pattern;
            len_q  <= in_len_s;
            busy_q <= 1'b1;
            gap_q  <= '0;
            if (bus.pause) begin
              idx_q   <= '0;
              reps_q  <= bus.load_reps;
              state_q <= ST_SHIFT;
            end else begin
              data_q       <= bit_s;
              data_valid_q <= 1'b1;
              idx_q        <= adv_idx_d;
              reps_q       <= adv_reps_d;
              state_q      <= adv_state_d;
            end
          end
        end
        ST_SHIFT: begin
          busy_q <= 1'b1;
          done_q <= 1'b0;
          if (bus.pause) begin
            data_valid_q <= 1'b0;
          end else begin
            data_q       <= bit_s;
            data_valid_q <= 1'b1;
            idx_q        <= adv_idx_d;
            reps_q       <= adv_reps_d;
            gap_q        <= '0;
            state_q      <= adv_state_d;
          end
        end
        ST_GAP: begin
          data_valid_q <= 1'b0;
          if (gap_q == GAP_LAST) begin
            state_q <= ST_SHIFT;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        ST_FIN: begin
          data_valid_q <= 1'b0;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          data_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.load_ready = (state_q == ST_IDLE);
  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: two instances (no gap, two-cycle gap) share one stimulus
// stream and are compared cycle by cycle against a beat-list reference model.
module tb_seq_gen;
  import seq_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int LW = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          lv;
  logic [W-1:0]  lpat;
  logic [LW-1:0] llen;
  logic [CW-1:0] lreps;
  logic          pz;

  seq_gen_if #(.W(W), .CW(CW)) if0 ();
  seq_gen_if #(.W(W), .CW(CW)) if2 ();

  assign if0.load_valid   = lv;
  assign if0.load_pattern = lpat;
  assign if0.load_len     = llen;
  assign if0.load_reps    = lreps;
  assign if0.pause        = pz;
  assign if2.load_valid   = lv;
  assign if2.load_pattern = lpat;
  assign if2.load_len     = llen;
  assign if2.load_reps    = lreps;
  assign if2.pause        = pz;

  seq_gen #(.W(W), .CW(CW), .GAP_CYC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  seq_gen #(.W(W), .CW(CW), .GAP_CYC(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          mq [2][$];
  bit          m_idle [2];
  logic        m_data [2];
  logic        m_dv [2];
  logic        m_busy [2];
  logic        m_done [2];
  int          gapc [2] = '{0, 2};
  int          done_tick [2];
  logic [31:0] cap [2];
  int          ncap [2];
  int          t_since;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    mq[i].delete();
    m_idle[i] = 1'b1;
    m_data[i] = 1'b0;
    m_dv[i]   = 1'b0;
    m_busy[i] = 1'b0;
    m_done[i] = 1'b0;
  endtask

  // Each accepted load expands into a list of beats (bits and gap slots);
  // every clock edge consumes one entry unless a bit is stalled by pause.
  task automatic model_edge(input int i);
    int L;
    int f;
    if (!rst_n) begin
      model_reset(i);
      return;
    end
    if (m_idle[i] && !lv) begin
      m_dv[i]   = 1'b0;
      m_done[i] = 1'b0;
      m_busy[i] = 1'b0;
      return;
    end
    if (m_idle[i]) begin
      L = ((llen == 0) || (int'(llen) > W)) ? W : int'(llen);
      for (int r = 0; r <= int'(lreps); r++) begin
        for (int j = 0; j < L; j++) mq[i].push_back(int'((lpat >> (L - 1 - j)) & 8'd1));
        if (r < int'(lreps)) for (int g = 0; g < gapc[i]; g++) mq[i].push_back(2);
      end
      m_idle[i] = 1'b0;
    end
    m_done[i] = 1'b0;
    if (mq[i].size() == 0) begin
      m_dv[i]   = 1'b0;
      m_done[i] = 1'b1;
      m_busy[i] = 1'b0;
      m_idle[i] = 1'b1;
    end else begin
      f = mq[i][0];
      m_busy[i] = 1'b1;
      if (f == 2) begin
        void'(mq[i].pop_front());
        m_dv[i] = 1'b0;
      end else if (pz) begin
        m_dv[i] = 1'b0;
      end else begin
        void'(mq[i].pop_front());
        m_data[i] = f[0];
        m_dv[i]   = 1'b1;
      end
    end
  endtask

  task automatic obs_outs(input int i, output logic d, output logic dv, output logic b,
                          output logic dn, output logic lr);
    if (i == 0) begin
      d = if0.data; dv = if0.data_valid; b = if0.busy; dn = if0.done; lr = if0.load_ready;
    end else begin
      d = if2.data; dv = if2.data_valid; b = if2.busy; dn = if2.done; lr = if2.load_ready;
    end
  endtask

  task automatic tick();
    logic d, dv, b, dn, lr;
    @(posedge clk);
    #1;
    t_since++;
    for (int i = 0; i < 2; i++) begin
      model_edge(i);
      obs_outs(i, d, dv, b, dn, lr);
      check_eq($sformatf("g%0d_data@%0t", gapc[i], $time), 32'(d), 32'(m_data[i]));
      check_eq($sformatf("g%0d_valid@%0t", gapc[i], $time), 32'(dv), 32'(m_dv[i]));
      check_eq($sformatf("g%0d_busy@%0t", gapc[i], $time), 32'(b), 32'(m_busy[i]));
      check_eq($sformatf("g%0d_done@%0t", gapc[i], $time), 32'(dn), 32'(m_done[i]));
      check_eq($sformatf("g%0d_ready@%0t", gapc[i], $time), 32'(lr), 32'(m_idle[i]));
      if (dv === 1'b1) begin
        cap[i] = {cap[i][30:0], d};
        ncap[i]++;
      end
      if ((dn === 1'b1) && (done_tick[i] < 0)) done_tick[i] = t_since;
    end
  endtask

  task automatic run_txn(input logic [W-1:0] pat, input logic [LW-1:0] len,
                         input logic [CW-1:0] reps, input int pct, input bit junk,
                         input int ps, input int pl);
    int k;
    for (int i = 0; i < 2; i++) begin
      cap[i] = '0;
      ncap[i] = 0;
      done_tick[i] = -1;
    end
    t_since = 0;
    lv = 1'b1; lpat = pat; llen = len; lreps = reps;
    pz = (ps == 0 && pl > 0) || ($urandom_range(0, 99) < pct);
    tick();
    lv = 1'b0;
    k = 1;
    while (!(m_idle[0] && m_idle[1]) && k < 400) begin
      pz = ((k >= ps) && (k < ps + pl)) || ($urandom_range(0, 99) < pct);
      // Loads offered mid-transfer must be ignored by both generators.
      if (junk && !m_idle[0] && !m_idle[1] && mq[0].size() > 0 && mq[1].size() > 0) begin
        lv = 1'($urandom_range(0, 1));
        lpat = W'($urandom);
        llen = LW'($urandom);
        lreps = CW'($urandom);
      end else begin
        lv = 1'b0;
      end
      tick();
      k++;
    end
    lv = 1'b0;
    pz = 1'b0;
    check_eq("txn_bound", 32'(m_idle[0] && m_idle[1]), 32'd1);
  endtask

  initial begin
    logic d, dv, b, dn, lr;
    rst_n = 1'b0; lv = 1'b0; lpat = '0; llen = '0; lreps = '0; pz = 1'b0;
    model_reset(0);
    model_reset(1);

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run_txn(8'h06, 4'd4, 4'd0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check_eq("t2_bits", cap[i], 32'h6);
      check_eq("t2_nbits", 32'(ncap[i]), 32'd4);
      check_eq("t2_done_at", 32'(done_tick[i]), 32'd5);
    end

    run_txn(8'hA5, 4'd0, 4'd0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check_eq("t3_bits", cap[i], 32'hA5);
      check_eq("t3_done_at", 32'(done_tick[i]), 32'd9);
    end

    run_txn(8'h06, 4'd4, 4'd2, 0, 1'b0, 0, 0);
    check_eq("t4_bits_g0", cap[0], 32'h666);
    check_eq("t4_bits_g2", cap[1], 32'h666);
    check_eq("t4_done_g0", 32'(done_tick[0]), 32'd13);
    check_eq("t4_done_g2", 32'(done_tick[1]), 32'd17);

    run_txn(8'h06, 4'd4, 4'd0, 0, 1'b0, 2, 3);
    for (int i = 0; i < 2; i++) begin
      check_eq("t5_bits", cap[i], 32'h6);
      check_eq("t5_done_at", 32'(done_tick[i]), 32'd8);
    end

    run_txn(8'hF9, 4'd4, 4'd1, 0, 1'b1, 0, 0);
    for (int i = 0; i < 2; i++) check_eq("t6_junk_bits", cap[i], 32'h99);

    // Abort mid-transfer: reset lands between clock edges, after bit 1.
    lv = 1'b1; lpat = 8'hFF; llen = 4'd8; lreps = 4'd1;
    tick();
    lv = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      obs_outs(i, d, dv, b, dn, lr);
      check_eq("rst_async", {28'd0, d, dv, b, dn}, 32'd0);
      check_eq("rst_ready", 32'(lr), 32'd1);
    end
    repeat (2) tick();
    #3;
    rst_n = 1'b1;
    repeat (12) tick();

    for (int n = 0; n < 30; n++) begin
      run_txn(W'($urandom), LW'($urandom_range(0, 15)), CW'($urandom_range(0, 3)),
              20, 1'b1, 0, 0);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
